alarm_set_ctrl: RTL and testbench

ALARM_SET_CTRL -- requirements
Module: alarm_set_ctrl

---
 rtl/alarm_set_ctrl_pkg.sv | 32 +++
 rtl/alarm_set_ctrl_if.sv | 35 +++
 rtl/alarm_set_ctrl_btn_fsm.sv | 128 ++++++++++++
 rtl/alarm_set_ctrl.sv | 85 ++++++++
 tb/tb_alarm_set_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_set_ctrl_pkg.sv
// Shared types and constants for the alarm set controller: button FSM states,
// time-field widths/limits and the wrap-around increment helpers.
package alarm_pkg;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H_PRESS,
    ST_M_PRESS,
    ST_H_RPT,
    ST_M_RPT,
    ST_ABORT
  } btn_state_t;

  // max(1, clog2(n)): a single channel still needs a 1-bit selector
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [HOUR_W-1:0] hour_wrap_inc(input logic [HOUR_W-1:0] h);
    return (h >= HOUR_W'(HOUR_MAX)) ? '0 : h + 1'b1;
  endfunction

  function automatic logic [MIN_W-1:0] min_wrap_inc(input logic [MIN_W-1:0] m);
    return (m >= MIN_W'(MIN_MAX)) ? '0 : m + 1'b1;
  endfunction

endpackage

// File: rtl/alarm_set_ctrl_if.sv
// Button, channel-select, time-of-day and status bundle of the alarm set controller.
// master = environment driving buttons/time, slave = the controller.
interface alarm_set_ctrl_if
  import alarm_pkg::*;
#(
  parameter int NUM_CH = 4
);
  localparam int SEL_W = sel_width(NUM_CH);

  logic              set_en;
  logic              hours_set;
  logic              mins_set;
  logic [SEL_W-1:0]  ch_sel;
  logic [NUM_CH-1:0] ch_en;
  logic [HOUR_W-1:0] now_hour;
  logic [MIN_W-1:0]  now_min;
  logic              tick_min;

  logic              hours_inc;
  logic              mins_inc;
  logic [HOUR_W-1:0] sel_hour;
  logic [MIN_W-1:0]  sel_min;
  logic [NUM_CH-1:0] ring;

  modport master (
    output set_en, hours_set, mins_set, ch_sel, ch_en, now_hour, now_min, tick_min,
    input  hours_inc, mins_inc, sel_hour, sel_min, ring
  );

  modport slave (
    input  set_en, hours_set, mins_set, ch_sel, ch_en, now_hour, now_min, tick_min,
    output hours_inc, mins_inc, sel_hour, sel_min, ring
  );

endinterface

// File: rtl/alarm_set_ctrl_btn_fsm.sv
// Hours/minutes button FSM with hold and auto-repeat counters. The *_stb outputs
// mark the edge on which an increment commits; *_inc are the registered pulses.
module alarm_btn_fsm
  import alarm_pkg::*;
#(
  parameter int HOLD_CYC = 8,
  parameter int RPT_CYC  = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic set_en,
  input  logic hours_set,
  input  logic mins_set,
  output logic hour_stb,
  output logic min_stb,
  output logic hours_inc,
  output logic mins_inc,
  output logic idle
);

  localparam int CNT_MAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYC);

  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       btn;

  assign btn     = {hours_set, mins_set};
  assign cnt_inc = cnt + 1'b1;
  assign idle    = (state == ST_IDLE);

  // Commit decisions: release while pressing, hold threshold, or repeat period
  always_comb begin
    hour_stb = 1'b0;
    min_stb  = 1'b0;
    if (set_en) begin
      case (state)
        ST_H_PRESS: hour_stb = (btn == 2'b00) || (btn == 2'b10 && cnt_inc == HOLD_LAST);
        ST_M_PRESS: min_stb  = (btn == 2'b00) || (btn == 2'b01 && cnt_inc == HOLD_LAST);
        ST_H_RPT:   hour_stb = (btn == 2'b10) && (cnt_inc == RPT_LAST);
        ST_M_RPT:   min_stb  = (btn == 2'b01) && (cnt_inc == RPT_LAST);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hours_inc <= 1'b0;
      mins_inc  <= 1'b0;
    end else begin
      hours_inc <= hour_stb;
      mins_inc  <= min_stb;
      if (!set_en) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt <= '0;
            case (btn)
              2'b10:   state <= ST_H_PRESS;
              2'b01:   state <= ST_M_PRESS;
              2'b11:   state <= ST_ABORT;
              default: ;
            endcase
          end
          ST_H_PRESS: begin
            case (btn)
              2'b00: state <= ST_IDLE;
              2'b10: begin
                if (hour_stb) begin
                  state <= ST_H_RPT;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt_inc;
                end
              end
              default: state <= ST_ABORT;
            endcase
          end
          ST_M_PRESS: begin
            case (btn)
              2'b00: state <= ST_IDLE;
              2'b01: begin
                if (min_stb) begin
                  state <= ST_M_RPT;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt_inc;
                end
              end
              default: state <= ST_ABORT;
            endcase
          end
          ST_H_RPT: begin
            case (btn)
              2'b10:   cnt <= hour_stb ? '0 : cnt_inc;
              2'b00:   state <= ST_IDLE;
              default: state <= ST_ABORT;
            endcase
          end
          ST_M_RPT: begin
            case (btn)
              2'b01:   cnt <= min_stb ? '0 : cnt_inc;
              2'b00:   state <= ST_IDLE;
              default: state <= ST_ABORT;
            endcase
          end
          ST_ABORT: begin
            cnt <= '0;
            if (btn == 2'b00) state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/alarm_set_ctrl.sv
// Multi-channel alarm time storage with button editing and sticky ring flags.
// Increments commit on the same edge their pulse rises; sel_* is a combinational read.
module alarm_set_ctrl
  import alarm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int HOLD_CYC = 8,
  parameter int RPT_CYC  = 4
) (
  input logic             clk,
  input logic             reset_n,
  alarm_set_ctrl_if.slave bus
);

  localparam int SEL_W = sel_width(NUM_CH);

  logic              hour_stb;
  logic              min_stb;
  logic              hours_inc;
  logic              mins_inc;
  logic              idle;
  logic [SEL_W-1:0]  edit_ch;
  logic              edit_ok;
  logic [HOUR_W-1:0] hour_q [NUM_CH];
  logic [MIN_W-1:0]  min_q  [NUM_CH];
  logic [NUM_CH-1:0] ring_q;

  alarm_btn_fsm #(
    .HOLD_CYC (HOLD_CYC),
    .RPT_CYC  (RPT_CYC)
  ) u_btn_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_en    (bus.set_en),
    .hours_set (bus.hours_set),
    .mins_set  (bus.mins_set),
    .hour_stb  (hour_stb),
    .min_stb   (min_stb),
    .hours_inc (hours_inc),
    .mins_inc  (mins_inc),
    .idle      (idle)
  );

  // Tracking ch_sel only while idle freezes the target on the press-entry edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edit_ch <= '0;
    else if (idle) edit_ch <= bus.ch_sel;
  end

  assign edit_ok = (int'(edit_ch) < NUM_CH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        hour_q[i] <= '0;
        min_q[i]  <= '0;
      end
      ring_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (hour_stb && edit_ok && int'(edit_ch) == i) hour_q[i] <= hour_wrap_inc(hour_q[i]);
        if (min_stb && edit_ok && int'(edit_ch) == i)  min_q[i]  <= min_wrap_inc(min_q[i]);
        // Match uses the pre-increment stored value; clear has priority over set
        if (!bus.ch_en[i] || bus.set_en)
          ring_q[i] <= 1'b0;
        else if (bus.tick_min && hour_q[i] == bus.now_hour && min_q[i] == bus.now_min)
          ring_q[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.sel_hour = '0;
    bus.sel_min  = '0;
    if (int'(bus.ch_sel) < NUM_CH) begin
      bus.sel_hour = hour_q[bus.ch_sel];
      bus.sel_min  = min_q[bus.ch_sel];
    end
  end

  assign bus.hours_inc = hours_inc;
  assign bus.mins_inc  = mins_inc;
  assign bus.ring      = ring_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Scoreboarded bench: each test pushes the pulses it expects; a negedge monitor pops and checks them.
module tb_alarm_set_ctrl;

  localparam int NCH  = 4;
  localparam int HOLD = 8;
  localparam int RPT  = 4;

  typedef struct {
    bit     is_hour;
    int     val;
    longint cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset_n;
  longint cyc = 0;
  int     checks = 0;
  int     failures = 0;
  int     mh[NCH];
  int     mm[NCH];
  exp_t   sb[$];

  alarm_set_ctrl_if #(.NUM_CH(NCH)) bus ();

  alarm_set_ctrl #(
    .NUM_CH   (NCH),
    .HOLD_CYC (HOLD),
    .RPT_CYC  (RPT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    int   act;
    if (reset_n === 1'b1 && (bus.hours_inc === 1'b1 || bus.mins_inc === 1'b1)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL pulse_unexpected cyc=%0d hours_inc=%b mins_inc=%b required=no_pulse",
                 cyc, bus.hours_inc, bus.mins_inc);
      end else begin
        e   = sb.pop_front();
        act = e.is_hour ? int'(bus.sel_hour) : int'(bus.sel_min);
        if (bus.hours_inc !== e.is_hour || bus.mins_inc !== !e.is_hour || cyc !== e.cyc || act !== e.val) begin
          failures++;
          $display("FAIL pulse_match got hours_inc=%b mins_inc=%b cyc=%0d sel=%0d want hour=%0d cyc=%0d sel=%0d",
                   bus.hours_inc, bus.mins_inc, cyc, act, e.is_hour, e.cyc, e.val);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_inc(input bit hr, input int ch, input int disp, input longint at);
    exp_t e;
    if (hr) mh[ch] = (mh[ch] == 23) ? 0 : mh[ch] + 1;
    else    mm[ch] = (mm[ch] == 59) ? 0 : mm[ch] + 1;
    e.is_hour = hr;
    e.val     = hr ? mh[disp] : mm[disp];
    e.cyc     = at;
    sb.push_back(e);
  endtask

  task automatic tap(input bit hr, input int n);
    int ch;
    ch = int'(bus.ch_sel);
    push_inc(hr, ch, ch, cyc + n + 1);
    bus.hours_set = hr;
    bus.mins_set  = !hr;
    repeat (n) step();
    bus.hours_set = 1'b0;
    bus.mins_set  = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.set_en = 1'b0; bus.hours_set = 1'b0; bus.mins_set = 1'b0;
    bus.ch_sel = '0; bus.ch_en = '0; bus.now_hour = '0; bus.now_min = '0; bus.tick_min = 1'b0;
    for (int i = 0; i < NCH; i++) begin mh[i] = 0; mm[i] = 0; end
    #3;
    checks++;
    if ({bus.hours_inc, bus.mins_inc, bus.ring} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got inc=%b%b ring=%b want 0", bus.hours_inc, bus.mins_inc, bus.ring);
    end
    for (int i = 0; i < NCH; i++) begin
      bus.ch_sel = 2'(i);
      #1;
      checks++;
      if (bus.sel_hour !== 5'd0 || bus.sel_min !== 6'd0) begin
        failures++;
        $display("FAIL reset_store ch=%0d got %0d:%0d want 0:0", i, bus.sel_hour, bus.sel_min);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_tap();
    bus.set_en = 1'b1;
    bus.ch_sel = 2'd2;
    step();
    tap(1'b1, 3);
    step(); step();
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL tap_pending got %0d want 0", sb.size()); end
    for (int i = 0; i < NCH; i++) begin
      bus.ch_sel = 2'(i);
      step();
      checks++;
      if (int'(bus.sel_hour) !== mh[i] || int'(bus.sel_min) !== mm[i]) begin
        failures++;
        $display("FAIL tap_store ch=%0d got %0d:%0d want %0d:%0d", i, bus.sel_hour, bus.sel_min, mh[i], mm[i]);
      end
    end
  endtask

  task automatic test_hold();
    longint c;
    bus.ch_sel = 2'd2;
    step();
    c = cyc;
    bus.mins_set = 1'b1;
    for (int k = HOLD; k <= 20; k += RPT) push_inc(1'b0, 2, 2, c + k);
    repeat (20) step();
    bus.mins_set = 1'b0;
    repeat (3) step();
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL hold_pending got %0d want 0", sb.size()); end
    checks++;
    if (bus.sel_min !== 6'd4) begin failures++; $display("FAIL hold_min got %0d want 4", bus.sel_min); end
  endtask

  task automatic test_wrap();
    bus.ch_sel = 2'd0;
    step();
    repeat (24) tap(1'b1, 1);
    repeat (60) tap(1'b0, 1);
    step();
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL wrap_pending got %0d want 0", sb.size()); end
    checks++;
    if (bus.sel_hour !== 5'd0 || bus.sel_min !== 6'd0) begin
      failures++;
      $display("FAIL wrap_value got %0d:%0d want 0:0", bus.sel_hour, bus.sel_min);
    end
  endtask

  task automatic test_abort();
    bus.ch_sel = 2'd1;
    step();
    bus.hours_set = 1'b1; repeat (2) step();
    bus.mins_set  = 1'b1; repeat (3) step();
    bus.hours_set = 1'b0; repeat (2) step();
    bus.mins_set  = 1'b0; step();
    bus.hours_set = 1'b1; bus.mins_set = 1'b1; repeat (2) step();
    bus.hours_set = 1'b0; bus.mins_set = 1'b0; step();
    // set_en dropped mid-press must discard the release commit
    bus.hours_set = 1'b1; repeat (2) step();
    bus.set_en = 1'b0; step();
    bus.hours_set = 1'b0; bus.set_en = 1'b1; repeat (2) step();
    tap(1'b1, 2);
    step();
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL abort_pending got %0d want 0", sb.size()); end
    checks++;
    if (int'(bus.sel_hour) !== mh[1]) begin failures++; $display("FAIL abort_hour got %0d want %0d", bus.sel_hour, mh[1]); end
  endtask

  task automatic test_latch();
    longint c;
    bus.ch_sel = 2'd3;
    step();
    c = cyc;
    bus.hours_set = 1'b1;
    push_inc(1'b1, 3, 0, c + 4);
    repeat (2) step();
    bus.ch_sel = 2'd0;
    step();
    bus.hours_set = 1'b0;
    repeat (2) step();
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL latch_pending got %0d want 0", sb.size()); end
    for (int i = 0; i < NCH; i++) begin
      bus.ch_sel = 2'(i);
      step();
      checks++;
      if (int'(bus.sel_hour) !== mh[i] || int'(bus.sel_min) !== mm[i]) begin
        failures++;
        $display("FAIL latch_store ch=%0d got %0d:%0d want %0d:%0d", i, bus.sel_hour, bus.sel_min, mh[i], mm[i]);
      end
    end
  endtask

  task automatic test_ring();
    logic [NCH-1:0] want;
    bus.ch_sel = 2'd1;
    step();
    while (mh[1] != 7)  tap(1'b1, 1);
    while (mm[1] != 30) tap(1'b0, 1);
    step();
    bus.set_en = 1'b0; bus.ch_en = 4'b0010;
    bus.now_hour = 5'd7; bus.now_min = 6'd31; bus.tick_min = 1'b1;
    step(); bus.tick_min = 1'b0;
    checks++;
    if (bus.ring !== 4'b0000) begin failures++; $display("FAIL ring_nomatch got %b want 0000", bus.ring); end
    bus.now_min = 6'd30; bus.tick_min = 1'b1;
    step(); bus.tick_min = 1'b0;
    checks++;
    if (bus.ring !== 4'b0010) begin failures++; $display("FAIL ring_set got %b want 0010", bus.ring); end
    bus.now_min = 6'd45;
    repeat (2) step();
    checks++;
    if (bus.ring !== 4'b0010) begin failures++; $display("FAIL ring_sticky got %b want 0010", bus.ring); end
    bus.ch_en = 4'b0000;
    step();
    checks++;
    if (bus.ring !== 4'b0000) begin failures++; $display("FAIL ring_clr_en got %b want 0000", bus.ring); end
    bus.ch_en = 4'b0010; bus.now_min = 6'd30; bus.set_en = 1'b1; bus.tick_min = 1'b1;
    step(); bus.tick_min = 1'b0;
    checks++;
    if (bus.ring !== 4'b0000) begin failures++; $display("FAIL ring_set_en got %b want 0000", bus.ring); end
    bus.set_en = 1'b0; bus.ch_en = 4'b1111; bus.now_hour = 5'd0; bus.now_min = 6'd0; bus.tick_min = 1'b1;
    for (int i = 0; i < NCH; i++) want[i] = (mh[i] == 0 && mm[i] == 0);
    step(); bus.tick_min = 1'b0;
    checks++;
    if (bus.ring !== want) begin failures++; $display("FAIL ring_multi got %b want %b", bus.ring, want); end
  endtask

  task automatic test_reset_midhold();
    longint c;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.ring !== 4'b0000) begin failures++; $display("FAIL rst_ring got %b want 0000", bus.ring); end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < NCH; i++) begin mh[i] = 0; mm[i] = 0; end
    bus.ch_en = '0; bus.set_en = 1'b1; bus.ch_sel = 2'd2;
    step();
    c = cyc;
    bus.mins_set = 1'b1;
    push_inc(1'b0, 2, 2, c + HOLD);
    repeat (10) step();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.hours_inc !== 1'b0 || bus.mins_inc !== 1'b0 || bus.sel_min !== 6'd0) begin
      failures++;
      $display("FAIL rst_midhold got inc=%b%b min=%0d want 00 0", bus.hours_inc, bus.mins_inc, bus.sel_min);
    end
    mm[2] = 0;
    bus.mins_set = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL rst_pending got %0d want 0", sb.size()); end
    for (int i = 0; i < NCH; i++) begin
      bus.ch_sel = 2'(i);
      step();
      checks++;
      if (bus.sel_hour !== 5'd0 || bus.sel_min !== 6'd0 || bus.ring !== 4'b0000) begin
        failures++;
        $display("FAIL rst_store ch=%0d got %0d:%0d ring=%b want 0:0 0000", i, bus.sel_hour, bus.sel_min, bus.ring);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tap();
    test_hold();
    test_wrap();
    test_abort();
    test_latch();
    test_ring();
    test_reset_midhold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
